// File: rtl/mdec_pipe_if.sv
// Handshake bundle for mdec_pipe: index in, decoded word out, error counter.
// dec_mode exists only when MDEC_THERMO_EN is defined.
interface mdec_pipe_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
);
  logic             dec_in_valid;
  logic             dec_in_ready;
  logic [IN_W-1:0]  dec_in;
  logic             dec_out_valid;
  logic             dec_out_ready;
  logic [OUT_W-1:0] dec_out;
  logic             dec_err;
  logic [7:0]       dec_err_cnt;
  logic             dec_err_clr;
`ifdef MDEC_THERMO_EN
  logic             dec_mode;

  modport master (
    output dec_in_valid, dec_in, dec_out_ready, dec_err_clr, dec_mode,
    input  dec_in_ready, dec_out_valid, dec_out, dec_err, dec_err_cnt
  );
  modport slave (
    input  dec_in_valid, dec_in, dec_out_ready, dec_err_clr, dec_mode,
    output dec_in_ready, dec_out_valid, dec_out, dec_err, dec_err_cnt
  );
`else
  modport master (
    output dec_in_valid, dec_in, dec_out_ready, dec_err_clr,
    input  dec_in_ready, dec_out_valid, dec_out, dec_err, dec_err_cnt
  );
  modport slave (
    input  dec_in_valid, dec_in, dec_out_ready, dec_err_clr,
    output dec_in_ready, dec_out_valid, dec_out, dec_err, dec_err_cnt
  );
`endif
endinterface

// File: rtl/mdec_pipe.sv
// Registered index-to-one-hot decoder behind a two-entry skid buffer.
// Define MDEC_THERMO_EN to add a per-word thermometer mode (dec_mode).
module mdec_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic         dec_clk,
  input  logic         dec_rst_n,
  mdec_pipe_if.slave   bus
);

  typedef struct packed {
    logic [OUT_W-1:0] word;
    logic             err;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  // Index widened by one bit so OUT_W == 2^IN_W is representable.
  localparam logic [IN_W:0] LIM = (IN_W+1)'(OUT_W);

  logic [IN_W:0]    idx_x;
  logic [OUT_W-1:0] oh;
  ent_t             new_ent;

  assign idx_x = {1'b0, bus.dec_in};

  for (genvar i = 0; i < OUT_W; i++) begin : g_oh
    assign oh[i] = (idx_x == (IN_W+1)'(i));
  end

`ifdef MDEC_THERMO_EN
  logic [OUT_W-1:0] th;
  for (genvar i = 0; i < OUT_W; i++) begin : g_th
    assign th[i] = ((IN_W+1)'(i) <= idx_x);
  end
  assign new_ent.word = bus.dec_mode ? th : oh;
`else
  assign new_ent.word = oh;
`endif
  assign new_ent.err = (idx_x >= LIM);

  state_t state, nxt;
  ent_t   main_q, skid_q;
  logic   in_x, out_x, bad_x;
  logic   ld_main_new, ld_main_skid, ld_skid;
  logic [7:0] cnt_q;

  assign in_x  = bus.dec_in_valid && (state != FULL);
  assign out_x = (state != EMPTY) && bus.dec_out_ready;
  assign bad_x = in_x && new_ent.err;

  always_comb begin
    nxt          = state;
    ld_main_new  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (in_x) begin
        ld_main_new = 1'b1;
        nxt         = BUSY;
      end
      BUSY: begin
        if (in_x && out_x) begin
          ld_main_new = 1'b1;
        end else if (in_x) begin
          ld_skid = 1'b1;
          nxt     = FULL;
        end else if (out_x) begin
          nxt = EMPTY;
        end
      end
      FULL: if (out_x) begin
        ld_main_skid = 1'b1;
        nxt          = BUSY;
      end
      default: nxt = EMPTY;
    endcase
  end

  always_ff @(posedge dec_clk) begin
    if (!dec_rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= nxt;
      if (ld_main_new)       main_q <= new_ent;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= new_ent;
      // A clear racing an error still records that error.
      if (bus.dec_err_clr)               cnt_q <= {7'b0, bad_x};
      else if (bad_x && cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.dec_in_ready  = (state != FULL);
  assign bus.dec_out_valid = (state != EMPTY);
  assign bus.dec_out       = main_q.word;
  assign bus.dec_err       = main_q.err;
  assign bus.dec_err_cnt   = cnt_q;

endmodule

// File: tb/tb_mdec_pipe.sv
// Bench for mdec_pipe: two instances (OUT_W 8 and 6) share stimulus and are
// checked every cycle against a queue-based model of the two-entry buffer.
module tb_mdec_pipe;

  logic dec_clk = 1'b0;
  logic dec_rst_n = 1'b0;
  always #5 dec_clk = ~dec_clk;

  mdec_pipe_if #(.IN_W(3), .OUT_W(8)) b8 ();
  mdec_pipe_if #(.IN_W(3), .OUT_W(6)) b6 ();

  mdec_pipe #(.IN_W(3), .OUT_W(8)) u8 (.dec_clk(dec_clk), .dec_rst_n(dec_rst_n), .bus(b8));
  mdec_pipe #(.IN_W(3), .OUT_W(6)) u6 (.dec_clk(dec_clk), .dec_rst_n(dec_rst_n), .bus(b6));

  int n_chk = 0;
  int n_fail = 0;

  int q[$];          // accepted words: idx + 8*mode
  int c8 = 0, c6 = 0;
  bit fresh = 1'b1;  // nothing accepted since last reset

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dec_m(input int w, input int ow);
    int idx, md;
    idx = w % 8;
    md  = w / 8;
    if (md != 0) return (idx >= ow) ? ((32'd1 << ow) - 1) : ((32'd1 << (idx + 1)) - 1);
    return (idx < ow) ? (32'd1 << idx) : 32'd0;
  endfunction

  task automatic check_all();
    chk("vld8", 32'(b8.dec_out_valid), 32'(q.size() > 0));
    chk("vld6", 32'(b6.dec_out_valid), 32'(q.size() > 0));
    chk("rdy8", 32'(b8.dec_in_ready), 32'(q.size() < 2));
    chk("rdy6", 32'(b6.dec_in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out8", 32'(b8.dec_out), dec_m(q[0], 8));
      chk("err8", 32'(b8.dec_err), 32'((q[0] % 8) >= 8));
      chk("out6", 32'(b6.dec_out), dec_m(q[0], 6));
      chk("err6", 32'(b6.dec_err), 32'((q[0] % 8) >= 6));
    end else if (fresh) begin
      chk("rst_out8", 32'(b8.dec_out), 32'd0);
      chk("rst_err8", 32'(b8.dec_err), 32'd0);
      chk("rst_out6", 32'(b6.dec_out), 32'd0);
      chk("rst_err6", 32'(b6.dec_err), 32'd0);
    end
    chk("cnt8", 32'(b8.dec_err_cnt), 32'(c8));
    chk("cnt6", 32'(b6.dec_err_cnt), 32'(c6));
  endtask

  function automatic int upd_cnt(input int c, input bit clr, input bit err);
    if (clr) return err ? 1 : 0;
    if (err) return (c < 255) ? c + 1 : 255;
    return c;
  endfunction

  // Drive one cycle's inputs, advance the model, then check after the edge.
  task automatic cycle(input bit v, input int idx, input bit ordy, input bit clr,
                       input bit md, input bit rst_n);
    bit in_x, out_x, mdv;
`ifdef MDEC_THERMO_EN
    mdv = md;
    b8.dec_mode = md;
    b6.dec_mode = md;
`else
    mdv = 1'b0 & md;
`endif
    dec_rst_n        = rst_n;
    b8.dec_in_valid  = v;     b6.dec_in_valid  = v;
    b8.dec_in        = 3'(idx); b6.dec_in      = 3'(idx);
    b8.dec_out_ready = ordy;  b6.dec_out_ready = ordy;
    b8.dec_err_clr   = clr;   b6.dec_err_clr   = clr;
    if (!rst_n) begin
      q.delete();
      c8 = 0;
      c6 = 0;
      fresh = 1'b1;
    end else begin
      in_x  = v && (q.size() < 2);
      out_x = ordy && (q.size() > 0);
      c8 = upd_cnt(c8, clr, in_x && (idx >= 8));
      c6 = upd_cnt(c6, clr, in_x && (idx >= 6));
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        q.push_back(idx + 8 * int'(mdv));
        fresh = 1'b0;
      end
    end
    @(posedge dec_clk);
    @(negedge dec_clk);
    check_all();
  endtask

  initial begin
    @(negedge dec_clk);
    cycle(1, 5, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    // back-to-back stream, one word per cycle
    for (int i = 0; i < 8; i++) cycle(1, i, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    // stall with ready low for three cycles
    cycle(1, 2, 0, 0, 0, 1);
    cycle(1, 5, 0, 0, 0, 1);
    cycle(1, 6, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 6, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    // clean counter, then out-of-range for OUT_W=6
    cycle(0, 0, 1, 1, 0, 1);
    cycle(1, 6, 1, 0, 0, 1);
    cycle(1, 7, 1, 0, 0, 1);
    cycle(1, 3, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    // saturation then clear racing an error
    for (int i = 0; i < 300; i++) cycle(1, 6 + (i % 2), 1, 0, 0, 1);
    cycle(1, 7, 1, 1, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    // reset while FULL
    cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 2, 0, 0, 0, 1);
    cycle(1, 7, 0, 0, 0, 1);
    cycle(1, 3, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
`ifdef MDEC_THERMO_EN
    cycle(1, 0, 1, 0, 1, 1);
    cycle(1, 3, 1, 0, 1, 1);
    cycle(1, 7, 1, 0, 1, 1);
    cycle(1, 3, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
`endif
    // randomized traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 199) != 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdec_pipe.md
# mdec_pipe

Parametrised, registered index-to-one-hot decoder with valid/ready flow control on both sides. It converts an IN_W-bit index into an OUT_W-bit one-hot word through a two-entry skid buffer, so downstream back-pressure never drops or duplicates data. It flags indices that have no output bit and counts them. It sits between control/sequencer logic and blocks needing one-hot select lines (bank selects, channel enables), replacing fixed 3-to-8 registered decoders.

## Interface
- IN_W, 3, index width; legal range 1..8
- OUT_W, 8, output width; 2 ≤ OUT_W ≤ 2^IN_W
- dec_clk  in  1  clock, all logic on rising edge
- dec_rst_n  in  1  reset; reset is synchronous and active-low
- dec_in_valid  in  1  input index valid
- dec_in_ready  out  1  block can accept an input this cycle
- dec_in  in  IN_W  index
- dec_out_valid  out  1  dec_out/dec_err valid
- dec_out_ready  in  1  downstream accepts output this cycle
- dec_out  out  OUT_W  decoded word
- dec_err  out  1  current output came from an out-of-range index (index ≥ OUT_W)
- dec_err_cnt  out  8  saturating count of accepted out-of-range indices
- dec_err_clr  in  1  synchronous clear of dec_err_cnt
- dec_mode  in  1  0 = one-hot, 1 = thermometer (present only with MDEC_THERMO_EN)

## Operation
- Input transfer: dec_in_valid && dec_in_ready. Output transfer: dec_out_valid && dec_out_ready.
- Decode is done on the input side. One-hot: dec_out[i] = (dec_in == i). Index ≥ OUT_W gives dec_out = 0 and dec_err = 1.
- Storage is a main register (drives outputs) plus a skid register.
- States:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main valid, skid valid.
- EMPTY: an input transfer loads main and goes to BUSY.
- BUSY:
  - Input and output transfer together: main reloads, stays BUSY.
  - Input only: the word goes to skid, move to FULL.
  - Output only: move to EMPTY.
- FULL: no input accepted. An output transfer moves skid to main and goes to BUSY.
- dec_in_ready = !skid_valid, a pure decode of the skid-valid register with no combinational path from dec_out_ready.
- dec_out, dec_err hold stable while dec_out_valid && !dec_out_ready.
- Error counter:
  - Increments on each input transfer with index ≥ OUT_W.
  - Saturates at 255.
  - dec_err_clr alone sets it to 0.
  - dec_err_clr coincident with an erroneous input transfer sets it to 1, so the event is not lost.

## Timing
- Reset (dec_rst_n low at a rising edge):
  - State EMPTY, dec_out_valid = 0, dec_out = 0, dec_err = 0, dec_err_cnt = 0, skid cleared.
  - dec_in_ready reads 1 after the first reset edge.
  - Input transfers are ignored while dec_rst_n is low.
- Reset mid-operation discards main and skid contents without producing an output transfer.
- Latency: an input accepted at edge N is visible on dec_out with dec_out_valid = 1 after edge N (1 cycle) when the block was EMPTY or draining.
- Throughput: 1 word/cycle with dec_out_ready held high.
- After one stall cycle, dec_in_ready drops the following cycle. It returns 1 the cycle after the first output transfer out of FULL.
- dec_err_cnt updates one cycle after the accepting edge.

## Configuration
- MDEC_THERMO_EN defined:
  - dec_mode port exists and is sampled with dec_in on input transfer; it is stored per word.
  - Thermometer: dec_out[i] = (i ≤ dec_in).
  - Index ≥ OUT_W gives all ones and dec_err = 1, counted as in one-hot mode.
- MDEC_THERMO_EN undefined: dec_mode port absent; one-hot only; no thermometer logic synthesised.

## Test plan
- Reset then stream 0..7 with dec_out_ready = 1 (IN_W = 3, OUT_W = 8) -> dec_out = 0x01,0x02,…,0x80 on consecutive cycles, 1-cycle latency, dec_err = 0.
- Send 2, 5, 6 with dec_out_ready low for 3 cycles, then high -> dec_in_ready falls after the 2nd accept; outputs 0x04, 0x20, 0x40 in order, none lost or repeated.
- OUT_W = 6, inputs 6, 7, 3 -> dec_out 0x00 with dec_err = 1 twice, then 0x08 with dec_err = 0; dec_err_cnt = 2.
- Feed 300 out-of-range indices -> dec_err_cnt sticks at 255. Then assert dec_err_clr with an erroneous input in the same cycle -> dec_err_cnt = 1.
- Assert dec_rst_n low while FULL -> next cycle dec_out_valid = 0, dec_out = 0, dec_err_cnt = 0, dec_in_ready = 1; no stale output afterwards.
- With MDEC_THERMO_EN, dec_mode = 1, inputs 0, 3, 7 (OUT_W = 8) -> 0x01, 0x0F, 0xFF. Then dec_mode = 0, input 3 -> 0x08.
